// File: rtl/score_result_tracker_pkg.sv
// Shared types and constants for the round score tracker and its BCD converter.
// No datapath of its own; one helper performs the double-dabble digit adjust.
package score_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PLAY,
      S_DIVIDE,
      S_BCD,
      S_DONE
   } state_t;

   localparam int SCORE_MAX  = 1000000;
   localparam int NUM_W      = 27;
   localparam int BCD_DIGITS = 7;
   localparam int SCORE_W    = 20;

   // Add 3 to every digit that is 5 or more, so the following left shift carries correctly.
   function automatic logic [BCD_DIGITS*4-1:0] bcd_adjust(input logic [BCD_DIGITS*4-1:0] d);
      logic [BCD_DIGITS*4-1:0] r;
      r = d;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/score_result_tracker_bin2bcd.sv
// Sequential binary-to-BCD converter: one double-dabble step per cycle, 20 cycles from start to done.
// No backpressure; start restarts a conversion, clr abandons one, done holds until the next start/clr.
module bin2bcd_seq
   import score_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clr,
   input  logic                         start,
   input  logic [SCORE_W-1:0]           bin,
   output logic                         done,
   output logic [BCD_DIGITS-1:0][3:0]   digits
);

   logic [SCORE_W-1:0]                  bin_q;
   logic [BCD_DIGITS*4-1:0]             bcd_q;
   logic [4:0]                          cnt;
   logic                                active;
   logic [BCD_DIGITS*4-1:0]             src_bcd;
   logic [SCORE_W-1:0]                  src_bin;
   logic [BCD_DIGITS*4+SCORE_W-1:0]     shifted;

   // The start cycle already performs the first step on the fresh operand.
   assign src_bcd = start ? '0  : bcd_q;
   assign src_bin = start ? bin : bin_q;
   assign shifted = {bcd_adjust(src_bcd), src_bin} << 1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt    <= '0;
         active <= 1'b0;
      end else if (clr) begin
         cnt    <= '0;
         active <= 1'b0;
      end else if (start || (active && cnt != 5'(SCORE_W))) begin
         {bcd_q, bin_q} <= shifted;
         cnt            <= start ? 5'd1 : cnt + 5'd1;
         active         <= 1'b1;
      end
   end

   assign done   = active && (cnt == 5'(SCORE_W));
   assign digits = bcd_q;

endmodule

// File: rtl/score_result_tracker.sv
// Counts hits per round, then divides and BCD-converts the normalised score; fixed 48 cycles round_end->end_mode.
// No backpressure: pulses outside their valid state are dropped, round_start aborts any computation.
module score_result_tracker #(
   parameter int MAX_NOTES = 99,
   parameter int SCORE_MAX = score_pkg::SCORE_MAX,
   parameter int NUM_W     = score_pkg::NUM_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        round_start,
   input  logic [6:0]  total_notes,
   input  logic        hit_pulse,
   input  logic        round_end,
   output logic        busy,
   output logic        end_mode,
   output logic [19:0] score_value,
   output logic [3:0]  score_d6,
   output logic [3:0]  score_d5,
   output logic [3:0]  score_d4,
   output logic [3:0]  score_d3,
   output logic [3:0]  score_d2,
   output logic [3:0]  score_d1,
   output logic [3:0]  score_d0,
   output logic [6:0]  hit_count
);
   import score_pkg::*;

   state_t                       state, state_nxt;
   logic [6:0]                   tn;
   logic                         hit_ok;
   logic [6:0]                   hits_nxt;
   logic [NUM_W-1:0]             num_q;
   logic [6:0]                   rem_q;
   logic [7:0]                   trial;
   logic [4:0]                   div_cnt;
   logic [SCORE_W-1:0]           quotient;
   logic                         bcd_start;
   logic                         bcd_done;
   logic [BCD_DIGITS-1:0][3:0]   bcd_digits;
   logic [BCD_DIGITS-1:0][3:0]   digits_q;

   assign hit_ok   = (state == S_PLAY) && hit_pulse && (hit_count < tn);
   assign hits_nxt = hit_count + 7'(hit_ok);
   assign trial    = {rem_q, num_q[NUM_W-1]};
   // num_q shifts quotient bits in from the right; a zero-note chart always scores 0.
   assign quotient = (tn == 7'd0) ? '0 : num_q[SCORE_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      end_mode  = 1'b0;
      if (round_start) begin
         state_nxt = S_PLAY;
      end else begin
         case (state)
            S_PLAY:   if (round_end) state_nxt = S_DIVIDE;
            S_DIVIDE: if (div_cnt == 5'(NUM_W - 1)) state_nxt = S_BCD;
            S_BCD:    if (bcd_done) state_nxt = S_DONE;
            default:  ;
         endcase
      end
      busy     = (state == S_DIVIDE) || (state == S_BCD);
      end_mode = (state == S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tn          <= '0;
         hit_count   <= '0;
         num_q       <= '0;
         rem_q       <= '0;
         div_cnt     <= '0;
         bcd_start   <= 1'b0;
         score_value <= '0;
         digits_q    <= '0;
      end else begin
         bcd_start <= (state == S_DIVIDE) && (state_nxt == S_BCD);
         if (round_start) begin
            tn          <= (total_notes > 7'(MAX_NOTES)) ? 7'(MAX_NOTES) : total_notes;
            hit_count   <= '0;
            score_value <= '0;
            digits_q    <= '0;
         end else begin
            if (hit_ok) hit_count <= hits_nxt;
            if (state == S_PLAY && round_end) begin
               num_q   <= NUM_W'(hits_nxt) * NUM_W'(SCORE_MAX);
               rem_q   <= '0;
               div_cnt <= '0;
            end
            // Restoring division, one quotient bit per cycle, MSB first.
            if (state == S_DIVIDE) begin
               if (trial >= {1'b0, tn}) begin
                  rem_q <= 7'(trial - {1'b0, tn});
                  num_q <= {num_q[NUM_W-2:0], 1'b1};
               end else begin
                  rem_q <= trial[6:0];
                  num_q <= {num_q[NUM_W-2:0], 1'b0};
               end
               div_cnt <= div_cnt + 5'd1;
            end
            if (state == S_BCD && bcd_done) begin
               score_value <= quotient;
               digits_q    <= bcd_digits;
            end
         end
      end
   end

   bin2bcd_seq u_bin2bcd (
      .clk    (clk),
      .reset  (reset),
      .clr    (round_start),
      .start  (bcd_start),
      .bin    (quotient),
      .done   (bcd_done),
      .digits (bcd_digits)
   );

   assign score_d6 = digits_q[6];
   assign score_d5 = digits_q[5];
   assign score_d4 = digits_q[4];
   assign score_d3 = digits_q[3];
   assign score_d2 = digits_q[2];
   assign score_d1 = digits_q[1];
   assign score_d0 = digits_q[0];

endmodule

// File: tb/tb_score_result_tracker.sv
// Directed bench for score_result_tracker: behavioural round/score model compared every cycle, plus literal expectations.
module tb_score_result_tracker;

   logic        clk = 1'b0;
   logic        reset;
   logic        round_start;
   logic [6:0]  total_notes;
   logic        hit_pulse;
   logic        round_end;
   logic        busy;
   logic        end_mode;
   logic [19:0] score_value;
   logic [3:0]  score_d6, score_d5, score_d4, score_d3, score_d2, score_d1, score_d0;
   logic [6:0]  hit_count;
   logic [27:0] digits_all;

   int n_checks = 0;
   int n_fail   = 0;

   score_result_tracker dut (
      .clk         (clk),
      .reset       (reset),
      .round_start (round_start),
      .total_notes (total_notes),
      .hit_pulse   (hit_pulse),
      .round_end   (round_end),
      .busy        (busy),
      .end_mode    (end_mode),
      .score_value (score_value),
      .score_d6    (score_d6),
      .score_d5    (score_d5),
      .score_d4    (score_d4),
      .score_d3    (score_d3),
      .score_d2    (score_d2),
      .score_d1    (score_d1),
      .score_d0    (score_d0),
      .hit_count   (hit_count)
   );

   assign digits_all = {score_d6, score_d5, score_d4, score_d3, score_d2, score_d1, score_d0};

   always #5 clk = ~clk;

   // Model: phase 0 idle, 1 play, 2 computing, 3 done.
   int m_phase = 0, m_tn = 0, m_hits = 0, m_cnt = 0, m_score = 0, m_pend = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase = 0; m_tn = 0; m_hits = 0; m_score = 0; m_cnt = 0;
      end else if (round_start) begin
         m_tn = (int'(total_notes) > 99) ? 99 : int'(total_notes);
         m_hits = 0; m_score = 0; m_phase = 1;
      end else if (m_phase == 1) begin
         if (hit_pulse && m_hits < m_tn) m_hits++;
         if (round_end) begin
            m_phase = 2; m_cnt = 0;
            m_pend = (m_tn == 0) ? 0 : (m_hits * 1000000) / m_tn;
         end
      end else if (m_phase == 2) begin
         m_cnt++;
         if (m_cnt == 48) begin m_phase = 3; m_score = m_pend; end
      end
   end

   function automatic logic [27:0] to_bcd(input int v);
      logic [27:0] r;
      int x;
      r = '0; x = v;
      for (int i = 0; i < 7; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   logic [56:0] cmp_exp, cmp_act;
   always @(negedge clk) begin
      cmp_exp = {m_phase == 2, m_phase == 3, 20'(m_score), to_bcd(m_score), 7'(m_hits)};
      cmp_act = {busy, end_mode, score_value, digits_all, hit_count};
      n_checks++;
      if (cmp_act !== cmp_exp) begin
         n_fail++;
         $display("FAIL cycle_compare t=%0t actual=%h required=%h", $time, cmp_act, cmp_exp);
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_round(input int n);
      total_notes = 7'(n);
      round_start = 1'b1;
      @(negedge clk);
      round_start = 1'b0;
   endtask

   task automatic hits(input int k);
      repeat (k) begin
         hit_pulse = 1'b1;
         @(negedge clk);
         hit_pulse = 1'b0;
      end
   endtask

   task automatic end_round();
      round_end = 1'b1;
      @(negedge clk);
      round_end = 1'b0;
   endtask

   task automatic wait_done(output int lat, output bit all_busy);
      lat = 0;
      all_busy = busy;
      while (!end_mode && lat < 200) begin
         @(negedge clk);
         lat++;
         if (!end_mode && !busy) all_busy = 1'b0;
      end
   endtask

   int lat;
   bit all_busy;

   initial begin
      reset = 1'b1; round_start = 1'b0; total_notes = '0; hit_pulse = 1'b0; round_end = 1'b0;
      cyc(2);
      #2;
      chk("reset_outputs", longint'({busy, end_mode, score_value, digits_all, hit_count}), 0);
      @(negedge clk);
      reset = 1'b0;
      cyc(2);

      // Full clear
      start_round(50); hits(50); end_round();
      wait_done(lat, all_busy);
      #2;
      chk("full_latency", lat, 48);
      chk("full_busy", all_busy, 1);
      chk("full_score", score_value, 1000000);
      chk("full_digits", digits_all, 28'h1000000);
      end_round();
      cyc(3);
      #2;
      chk("done_hold_end", end_mode, 1);

      // Partial score
      start_round(99); hits(70); end_round();
      wait_done(lat, all_busy);
      #2;
      chk("p70_score", score_value, 707070);
      chk("p70_digits", digits_all, 28'h0707070);
      chk("p70_hits", hit_count, 70);

      // Zero-note chart, round_end right after round_start
      start_round(0); end_round();
      wait_done(lat, all_busy);
      #2;
      chk("tn0_latency", lat, 48);
      chk("tn0_score", score_value, 0);
      chk("tn0_digits", digits_all, 0);
      chk("tn0_nox", longint'($isunknown({busy, end_mode, score_value, digits_all, hit_count})), 0);

      // Saturation
      start_round(3); hits(5); end_round();
      wait_done(lat, all_busy);
      #2;
      chk("sat_hits", hit_count, 3);
      chk("sat_score", score_value, 1000000);

      // Hit in the same cycle as round_end
      start_round(4); hits(2);
      hit_pulse = 1'b1; round_end = 1'b1;
      @(negedge clk);
      hit_pulse = 1'b0; round_end = 1'b0;
      wait_done(lat, all_busy);
      #2;
      chk("same_hits", hit_count, 3);
      chk("same_score", score_value, 750000);

      // total_notes clamp
      start_round(120); hits(100); end_round();
      wait_done(lat, all_busy);
      #2;
      chk("clamp_hits", hit_count, 99);
      chk("clamp_score", score_value, 1000000);

      // Reset mid-divide
      start_round(10); hits(5); end_round(); cyc(20);
      #1 reset = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_end", end_mode, 0);
      chk("rst_score", score_value, 0);
      chk("rst_hits", hit_count, 0);
      @(negedge clk);
      reset = 1'b0;
      end_round(); hits(1); cyc(60);
      #2;
      chk("rst_end_ignored", end_mode, 0);
      chk("rst_hit_ignored", hit_count, 0);

      // round_start 10 cycles into BCD
      start_round(10); hits(5); end_round(); cyc(37);
      start_round(8);
      #2;
      chk("abort_busy", busy, 0);
      chk("abort_end", end_mode, 0);
      chk("abort_score", score_value, 0);
      chk("abort_hits", hit_count, 0);
      hits(2); end_round();
      wait_done(lat, all_busy);
      #2;
      chk("abort_latency", lat, 48);
      chk("abort_new_score", score_value, 250000);
      chk("abort_new_digits", digits_all, 28'h0250000);

      cyc(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
